// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Sequences the three screen-render engines (fillscreen, makegrid,
//   mapbuilder) in fixed order fill -> grid -> map and owns the single pixel
//   port into vga_adapter. Accepts full and map-only redraw requests, queues
//   at most one pass while busy, and guards each stage with a watchdog.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req_full, req_map, stage_mask redraw requests; mask bit0 fill, bit1 grid, bit2 map
//   <eng>_start / <eng>_done      per-engine handshake (eng = fill, grid, map)
//   <eng>_x/_y/_colour/_plot      per-engine pixel outputs
//   vga_x/_y/_colour/_plot        muxed pixel port to vga_adapter
//   busy, frame_done              status: not idle / one-cycle end-of-pass pulse
//   timeout_err, frames_drawn     sticky abort flag / passes completed cleanly
module draw_scheduler #(
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd131072
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_full,
    input  logic       req_map,
    input  logic [2:0] stage_mask,
    output logic       fill_start,
    input  logic       fill_done,
    input  logic [8:0] fill_x,
    input  logic [7:0] fill_y,
    input  logic [2:0] fill_colour,
    input  logic       fill_plot,
    output logic       grid_start,
    input  logic       grid_done,
    input  logic [8:0] grid_x,
    input  logic [7:0] grid_y,
    input  logic [2:0] grid_colour,
    input  logic       grid_plot,
    output logic       map_start,
    input  logic       map_done,
    input  logic [8:0] map_x,
    input  logic [7:0] map_y,
    input  logic [2:0] map_colour,
    input  logic       map_plot,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic [7:0] frames_drawn
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_FILL = 3'd1,
        RUN_GRID = 3'd2,
        RUN_MAP  = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      mask_q, mask_nxt;
    logic            pend_full, pend_map;
    logic [TO_W-1:0] wd_cnt;
    logic            accept;
    logic            in_run;
    logic            stage_done;
    logic            wd_hit;
    logic            timeout_set;

    // First enabled stage of a mask, in fill -> grid -> map order.
    function automatic state_t first_stage(input logic [2:0] m);
        if (m[0])      return RUN_FILL;
        else if (m[1]) return RUN_GRID;
        else if (m[2]) return RUN_MAP;
        else           return DONE;
    endfunction

    // Next stage after s: mask off s and everything before it.
    function automatic state_t stage_after(input state_t s, input logic [2:0] m);
        case (s)
            RUN_FILL: return first_stage({m[2:1], 1'b0});
            RUN_GRID: return first_stage({m[2], 2'b00});
            default:  return DONE;
        endcase
    endfunction

    wire want_full = req_full | pend_full;
    wire want_map  = req_map  | pend_map;

    assign in_run = (state == RUN_FILL) || (state == RUN_GRID) || (state == RUN_MAP);

    // Only the active engine's done matters.
    always_comb begin
        stage_done = 1'b0;
        case (state)
            RUN_FILL: stage_done = fill_done;
            RUN_GRID: stage_done = grid_done;
            RUN_MAP:  stage_done = map_done;
            default:  stage_done = 1'b0;
        endcase
    end

    // A zero limit disables the watchdog entirely.
    assign wd_hit      = (TIMEOUT_CYCLES != '0) && (wd_cnt == TIMEOUT_CYCLES - TO_W'(1));
    assign timeout_set = in_run && !stage_done && wd_hit;

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Full requests win over map-only; live and pending are equivalent.
                if (want_full) begin
                    accept    = 1'b1;
                    mask_nxt  = stage_mask;
                    state_nxt = first_stage(stage_mask);
                end else if (want_map) begin
                    accept    = 1'b1;
                    mask_nxt  = 3'b100;
                    state_nxt = RUN_MAP;
                end
            end
            RUN_FILL, RUN_GRID, RUN_MAP: begin
                if (stage_done)  state_nxt = stage_after(state, mask_q);
                else if (wd_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they change
    // exactly with the state and never glitch on decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mask_q       <= 3'b000;
            pend_full    <= 1'b0;
            pend_map     <= 1'b0;
            wd_cnt       <= '0;
            fill_start   <= 1'b0;
            grid_start   <= 1'b0;
            map_start    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            frames_drawn <= 8'd0;
        end else begin
            state      <= state_nxt;
            mask_q     <= mask_nxt;
            fill_start <= (state_nxt == RUN_FILL);
            grid_start <= (state_nxt == RUN_GRID);
            map_start  <= (state_nxt == RUN_MAP);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);

            // Stage entry is always a state change, so that clears the counter.
            if (state_nxt != state)
                wd_cnt <= '0;
            else if (in_run && (wd_cnt != '1))
                wd_cnt <= wd_cnt + TO_W'(1);

            if (accept)
                timeout_err <= 1'b0;
            else if (timeout_set)
                timeout_err <= 1'b1;

            // One queued pass at most: repeats just re-set the same flags.
            if (accept) begin
                pend_full <= 1'b0;
                pend_map  <= 1'b0;
            end else if (state != IDLE) begin
                if (req_full) pend_full <= 1'b1;
                if (req_map)  pend_map  <= 1'b1;
            end

            // timeout_err is cleared on acceptance, so in DONE it reflects this pass.
            if ((state == DONE) && !timeout_err)
                frames_drawn <= frames_drawn + 8'd1;
        end
    end

    always_comb begin
        vga_x      = 9'd0;
        vga_y      = 8'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state)
            RUN_FILL: begin
                vga_x = fill_x; vga_y = fill_y; vga_colour = fill_colour; vga_plot = fill_plot;
            end
            RUN_GRID: begin
                vga_x = grid_x; vga_y = grid_y; vga_colour = grid_colour; vga_plot = grid_plot;
            end
            RUN_MAP: begin
                vga_x = map_x; vga_y = map_y; vga_colour = map_colour; vga_plot = map_plot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_full = 1'b0, req_map = 1'b0;
    logic [2:0] stage_mask = 3'b000;
    logic       fill_start, grid_start, map_start;
    logic       fill_done, grid_done, map_done;
    logic [8:0] fill_x, grid_x, map_x, vga_x;
    logic [7:0] fill_y, grid_y, map_y, vga_y;
    logic [2:0] fill_colour, grid_colour, map_colour, vga_colour;
    logic       fill_plot, grid_plot, map_plot, vga_plot;
    logic       busy, frame_done, timeout_err;
    logic [7:0] frames_drawn;
    logic       grid_hang = 1'b0;

    always #5 clk = ~clk;

    draw_scheduler #(.TO_W(24), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_full(req_full), .req_map(req_map), .stage_mask(stage_mask),
        .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
        .fill_colour(fill_colour), .fill_plot(fill_plot),
        .grid_start(grid_start), .grid_done(grid_done), .grid_x(grid_x), .grid_y(grid_y),
        .grid_colour(grid_colour), .grid_plot(grid_plot),
        .map_start(map_start), .map_done(map_done), .map_x(map_x), .map_y(map_y),
        .map_colour(map_colour), .map_plot(map_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
        .frames_drawn(frames_drawn)
    );

    // Engine models: done in the 10th cycle of start; fixed pixel signature each.
    logic [7:0] fc, gc, mc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin fc <= 0; gc <= 0; mc <= 0; end
        else begin
            fc <= fill_start ? fc + 8'd1 : 8'd0;
            gc <= grid_start ? gc + 8'd1 : 8'd0;
            mc <= map_start  ? mc + 8'd1 : 8'd0;
        end
    assign fill_done = fill_start && fc == 8'd9;
    assign grid_done = grid_start && gc == 8'd9 && !grid_hang;
    assign map_done  = map_start  && mc == 8'd9;
    assign fill_x = 9'd1; assign fill_y = 8'd2; assign fill_colour = 3'd3; assign fill_plot = 1'b1;
    assign grid_x = 9'd4; assign grid_y = 8'd5; assign grid_colour = 3'd6; assign grid_plot = 1'b1;
    assign map_x  = 9'd7; assign map_y  = 8'd8; assign map_colour  = 3'd5; assign map_plot  = 1'b1;

    // Cycle monitor: start occupancy, overlaps, gaps, pixel-mux correctness.
    int n_fill = 0, n_grid = 0, n_map = 0, n_fd = 0, n_ov = 0, n_gap = 0, n_vga = 0;
    logic [20:0] vga_exp;
    always @(negedge clk) if (rst_n) begin
        n_fill <= n_fill + int'(fill_start);
        n_grid <= n_grid + int'(grid_start);
        n_map  <= n_map  + int'(map_start);
        n_fd   <= n_fd   + int'(frame_done);
        if (int'(fill_start) + int'(grid_start) + int'(map_start) > 1) n_ov <= n_ov + 1;
        if (busy && !fill_start && !grid_start && !map_start && !frame_done) n_gap <= n_gap + 1;
        if (fill_start)      vga_exp = {9'd1, 8'd2, 3'd3, 1'b1};
        else if (grid_start) vga_exp = {9'd4, 8'd5, 3'd6, 1'b1};
        else if (map_start)  vga_exp = {9'd7, 8'd8, 3'd5, 1'b1};
        else                 vga_exp = '0;
        if ({vga_x, vga_y, vga_colour, vga_plot} != vga_exp) n_vga <= n_vga + 1;
    end

    int n_checks = 0, n_fail = 0;
    int exp_frames = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_fd(input int target, input string name);
        int k = 0;
        while (n_fd < target && k < 300) begin step(); k++; end
        chk(name, int'(n_fd >= target), 1);
    endtask

    typedef struct {
        logic       rf, rm, hang;
        logic [2:0] mask;
        logic [3:0] first;   // {fill_start, grid_start, map_start, frame_done} one cycle after accept
        int         nf, ng, nm;
        logic       to;
        int         dframes;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int s_f, s_g, s_m, s_fd, s_ov, s_gap, s_vga;
        string p;
        p = $sformatf("v%0d_", idx);
        s_f = n_fill; s_g = n_grid; s_m = n_map; s_fd = n_fd;
        s_ov = n_ov; s_gap = n_gap; s_vga = n_vga;
        grid_hang = v.hang;
        step(); req_full = v.rf; req_map = v.rm; stage_mask = v.mask;
        step(); req_full = 1'b0; req_map = 1'b0;
        chk({p, "first"}, {fill_start, grid_start, map_start, frame_done}, v.first);
        wait_fd(s_fd + 1, {p, "frame_done_seen"});
        grid_hang = 1'b0;
        step();
        exp_frames = (exp_frames + v.dframes) % 256;
        chk({p, "fill_cycles"}, n_fill - s_f, v.nf);
        chk({p, "grid_cycles"}, n_grid - s_g, v.ng);
        chk({p, "map_cycles"},  n_map - s_m,  v.nm);
        chk({p, "frame_done_pulses"}, n_fd - s_fd, 1);
        chk({p, "overlap"}, n_ov - s_ov, 0);
        chk({p, "gap"}, n_gap - s_gap, 0);
        chk({p, "vga_mux"}, n_vga - s_vga, 0);
        chk({p, "timeout_err"}, timeout_err, v.to);
        chk({p, "frames_drawn"}, frames_drawn, exp_frames);
        step(); step();
        chk({p, "idle_after"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        //        rf  rm  hang mask    first    nf  ng  nm  to  df
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b111, 4'b1000, 10, 10, 10, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b011, 4'b0010,  0,  0, 10, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 3'b000, 4'b0001,  0,  0,  0, 1'b0, 1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 3'b101, 4'b1000, 10,  0, 10, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 3'b010, 4'b0100,  0, 10,  0, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 3'b110, 4'b0100,  0, 10, 10, 1'b0, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 3'b111, 4'b1000, 10, 16,  0, 1'b1, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 3'b111, 4'b0010,  0,  0, 10, 1'b0, 1};

        step(); step();
        chk("rst_starts", {fill_start, grid_start, map_start}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_frames", frames_drawn, 0);
        chk("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Coalescing: map pass running, then req_map x2 + req_full -> one full pass queued.
        begin
            int s_f, s_g, s_m, s_fd;
            s_f = n_fill; s_g = n_grid; s_m = n_map; s_fd = n_fd;
            stage_mask = 3'b111;
            step(); req_map = 1'b1;
            step(); req_map = 1'b0;
            step(); req_map = 1'b1;
            step(); req_map = 1'b0;
            step(); req_map = 1'b1;
            step(); req_map = 1'b0; req_full = 1'b1;
            step(); req_full = 1'b0;
            chk("coal_still_map", map_start, 1);
            wait_fd(s_fd + 2, "coal_two_passes");
            step();
            exp_frames = (exp_frames + 2) % 256;
            chk("coal_fill", n_fill - s_f, 10);
            chk("coal_grid", n_grid - s_g, 10);
            chk("coal_map", n_map - s_m, 20);
            chk("coal_frames", frames_drawn, exp_frames);
            step(); step(); step();
            chk("coal_queue_empty", busy, 0);
            chk("coal_fd_total", n_fd - s_fd, 2);
        end

        // Reset mid-RUN_GRID with a map request pending.
        begin
            int k = 0;
            step(); req_full = 1'b1; stage_mask = 3'b111;
            step(); req_full = 1'b0; req_map = 1'b1;
            step(); req_map = 1'b0;
            while (!grid_start && k < 50) begin step(); k++; end
            chk("rst_mid_reached_grid", grid_start, 1);
            step(); step();
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_grid_start", grid_start, 0);
            chk("rst_mid_vga_plot", vga_plot, 0);
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_frames", frames_drawn, 0);
            exp_frames = 0;
            step(); step();
            rst_n = 1'b1;
            step(); step(); step();
            chk("rst_mid_idle", busy, 0);
            chk("rst_mid_no_pending", {fill_start, grid_start, map_start}, 0);
        end

        run_vec(vecs[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences the three screen-render engines (fillscreen, makegrid, mapbuilder) and owns the single pixel port into vga_adapter.
- Accepts full-redraw and map-only redraw requests from game logic.
- Holds at most one pending request while a pass is active, runs the enabled stages in fixed order fill -> grid -> map, and reports completion and stalls.
- Replaces the hand-written start/done muxing in the top-level game controllers.

Parameters:
- TIMEOUT_CYCLES, 24'd131072: max cycles one stage may run before abort; 0 disables the watchdog.
- TO_W, 24: width of the watchdog counter.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous active-low reset
- req_full  in  1  level/pulse; request full redraw using stage_mask
- req_map  in  1  level/pulse; request map-only redraw
- stage_mask  in  3  bit0 fill, bit1 grid, bit2 map; sampled when a full request is accepted
- fill_start  out  1  start to fillscreen
- fill_done  in  1  done from fillscreen
- fill_x  in  9, fill_y  in  8, fill_colour  in  3, fill_plot  in  1  fillscreen pixel outputs
- grid_start  out  1, grid_done  in  1, grid_x  in  9, grid_y  in  8, grid_colour  in  3, grid_plot  in  1  makegrid handshake and pixel outputs
- map_start  out  1, map_done  in  1, map_x  in  9, map_y  in  8, map_colour  in  3, map_plot  in  1  mapbuilder handshake and pixel outputs
- vga_x  out  9, vga_y  out  8, vga_colour  out  3, vga_plot  out  1  to vga_adapter
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of every pass
- timeout_err  out  1  sticky abort flag
- frames_drawn  out  8  count of passes completed without timeout

Behaviour:
- Reset values: state IDLE; all *_start=0; vga_plot=0; vga_x/y/colour=0; busy=0; frame_done=0; timeout_err=0; frames_drawn=0; pending flags cleared; latched mask=0. Reset asserted mid-pass drops every start line immediately.
- States:
  - IDLE
  - RUN_FILL
  - RUN_GRID
  - RUN_MAP
  - DONE
- Acceptance in IDLE:
  - Sources are the live req_full/req_map and the pending_full/pending_map flags.
  - Full requests (live or pending) beat map requests; live and pending requests of the same kind are equivalent.
  - Full request: the latched mask is stage_mask. Map request: the latched mask is 3'b100.
  - Acceptance clears both pending flags and timeout_err.
  - Next state is the first enabled stage in order fill, grid, map. If the mask is 000, next state is DONE.
- Latency: a request accepted at edge k gives the state change at edge k and the engine start high during cycle k+1.
- Handshake:
  - The active engine's start is held high for the whole RUN_x state.
  - When that engine's done=1 is sampled, the next edge moves to the next enabled stage (or DONE). The finished start falls and the next start rises in the same cycle.
  - done from inactive engines is ignored.
- Pixel mux is combinational.
  - In RUN_x, vga_* = that engine's x/y/colour/plot.
  - In IDLE and DONE, vga_plot=0 and x/y/colour=0.
- Requests while busy:
  - req_full sets pending_full; req_map sets pending_map. Both may be set.
  - Repeat requests coalesce; at most one pass is queued.
- DONE lasts exactly one cycle, with frame_done=1, then goes to IDLE.
  - frames_drawn increments (wraps 255->0) unless the pass ended by timeout.
  - The earliest restart for a pending request is the IDLE cycle after DONE.
- Watchdog:
  - The counter clears on entry to each RUN_x and increments each cycle in that stage.
  - If it reaches TIMEOUT_CYCLES-1 with done still 0: timeout_err<=1 and go to DONE, skipping the remaining stages.
  - The counter saturates and never wraps.

Test Plan:
- Reset, then req_full pulse with mask=111; each engine model asserts done 10 cycles after start -> fill, grid and map starts high in sequence with no overlap and no gap cycle; frame_done pulses once; frames_drawn=1; vga_plot mirrors only the active engine.
- req_map pulse from IDLE -> only map_start asserts; fill_start and grid_start stay 0; frames_drawn increments.
- During a map-only pass, pulse req_map twice and req_full once -> exactly one further pass, a full one; both pending flags clear; frames_drawn advances by 2 total.
- req_full with mask=000 -> DONE the cycle after acceptance, frame_done=1, no start asserted; mask=101 -> grid skipped.
- TIMEOUT_CYCLES=16, grid model never asserts done -> abort after 16 grid cycles; timeout_err=1; map not started; frames_drawn unchanged; next accepted request clears timeout_err.
- rst_n low mid-RUN_GRID -> grid_start, vga_plot and busy drop asynchronously; after release, state is IDLE and the pending queue is empty.
